// File: rtl/spi_word_rx.sv
// SPI slave word receiver (any SPI mode) feeding a show-ahead word FIFO.
// Define SPI_WORD_RX_TIMEOUT_EN to abort frames after TIMEOUT_CYC idle clocks.
module spi_word_rx #(
    parameter int unsigned WORD_W      = 8,
    parameter bit          CPOL        = 1'b0,
    parameter bit          CPHA        = 1'b0,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    input  logic              spi_cs_n,
    input  logic              rd_en,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              fifo_full,
    output logic              overflow,
    output logic              frame_err,
    output logic [15:0]       word_count
);

    localparam int unsigned CNT_W = $clog2(WORD_W);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam bit          SAMPLE_RISE = ((CPOL ^ CPHA) == 1'b0);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    if (WORD_W < 2 || WORD_W > 32) begin : g_bad_word_w
        $error("spi_word_rx: WORD_W must be 2..32");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("spi_word_rx: SYNC_STAGES must be 2..4");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("spi_word_rx: FIFO_DEPTH must be a power of two in 2..16");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("spi_word_rx: TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_PUSH
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, csn_sync_q;
    logic                   sclk_prev_q, csn_prev_q;
    logic                   sclk_s, mosi_s, csn_s;
    logic                   sample_edge;
    logic                   edge_q, cs_rise_q, mosi_bit_q;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]      shift_q, shift_d;
    logic                   push, frame_err_d, idle_block;

    logic [WORD_W-1:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]          count_q, count_d;
    logic                   rd_valid_q, full_q, overflow_q, frame_err_q;
    logic                   do_push, do_pop, overflow_d;
    logic [15:0]            word_count_q;

`ifdef SPI_WORD_RX_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic                   lock_q, lock_d;

    assign idle_block = lock_q;
`else
    assign idle_block = 1'b0;
`endif

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign csn_s  = csn_sync_q[SYNC_STAGES-1];

    assign sample_edge = SAMPLE_RISE ? (sclk_s & ~sclk_prev_q) : (~sclk_s & sclk_prev_q);

    // Edge and cs_n-rise events are registered together so a sample edge
    // coinciding with the cs_n rise is seen by the FSM in the same cycle and dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= {SYNC_STAGES{CPOL}};
            mosi_sync_q <= '0;
            csn_sync_q  <= '1;
            sclk_prev_q <= CPOL;
            csn_prev_q  <= 1'b1;
            edge_q      <= 1'b0;
            cs_rise_q   <= 1'b0;
            mosi_bit_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            sclk_prev_q <= sclk_s;
            csn_prev_q  <= csn_s;
            edge_q      <= sample_edge;
            cs_rise_q   <= csn_s & ~csn_prev_q;
            mosi_bit_q  <= mosi_s;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
`ifdef SPI_WORD_RX_TIMEOUT_EN
        to_cnt_d    = '0;
        lock_d      = csn_s ? 1'b0 : lock_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!csn_s && !idle_block) begin
                    state_d   = S_SHIFT;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            S_SHIFT: begin
                if (edge_q) begin
                    shift_d = {shift_q[WORD_W-2:0], mosi_bit_q};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = S_PUSH;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
`ifdef SPI_WORD_RX_TIMEOUT_EN
                else if (to_cnt_q == TO_W'(TIMEOUT_CYC)) begin
                    state_d     = S_IDLE;
                    frame_err_d = (bit_cnt_q != '0);
                    bit_cnt_d   = '0;
                    lock_d      = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
`endif
            end
            S_PUSH: begin
                push    = 1'b1;
                state_d = S_SHIFT;
            end
            default: state_d = S_IDLE;
        endcase

        if (cs_rise_q) begin
            state_d     = S_IDLE;
            bit_cnt_d   = '0;
            frame_err_d = (bit_cnt_q != '0);
`ifdef SPI_WORD_RX_TIMEOUT_EN
            lock_d      = 1'b0;
`endif
        end
    end

    assign do_pop     = rd_en & rd_valid_q;
    assign do_push    = push & (~full_q | do_pop);
    assign overflow_d = push & full_q & ~do_pop;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rd_valid_q   <= 1'b0;
            full_q       <= 1'b0;
            overflow_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            word_count_q <= '0;
`ifdef SPI_WORD_RX_TIMEOUT_EN
            to_cnt_q     <= '0;
            lock_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            count_q     <= count_d;
            rd_valid_q  <= (count_d != '0);
            full_q      <= (count_d == CW'(FIFO_DEPTH));
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
            if (do_push) begin
                wr_ptr_q     <= wr_ptr_q + AW'(1);
                word_count_q <= word_count_q + 16'd1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
`ifdef SPI_WORD_RX_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
            lock_q      <= lock_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign rd_data    = rd_valid_q ? mem_q[rd_ptr_q] : '0;
    assign rd_valid   = rd_valid_q;
    assign fifo_full  = full_q;
    assign overflow   = overflow_q;
    assign frame_err  = frame_err_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_spi_word_rx.sv
// Directed bench for spi_word_rx: one instance per SPI mode/width under test,
// SPI edges placed on clk negedges so the receive latency is exact.
module tb_spi_word_rx;

    localparam int H = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mosi = 1'b0;
    logic [3:0]  sclk_v = 4'b0010;
    logic [3:0]  csn_v = 4'b1111;
    logic [3:0]  rd_en_v = 4'b0000;

    wire  [3:0]  rdv_w, full_w, ovf_w, ferr_w;
    wire  [15:0] wc [4];
    wire  [7:0]  d0, d3;
    wire  [11:0] d1, d2;
    wire  [31:0] rdd [4];

    int checks = 0;
    int errors = 0;
    int ferr_cnt [4] = '{default: 0};
    int ovf_cnt  [4] = '{default: 0};

    assign rdd[0] = {24'd0, d0};
    assign rdd[1] = {20'd0, d1};
    assign rdd[2] = {20'd0, d2};
    assign rdd[3] = {24'd0, d3};

    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (ferr_w[d]) ferr_cnt[d]++;
            if (ovf_w[d])  ovf_cnt[d]++;
        end
    end

    spi_word_rx #(.WORD_W(8), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
        .clk(clk), .rst(rst), .spi_clk(sclk_v[0]), .spi_mosi(mosi), .spi_cs_n(csn_v[0]),
        .rd_en(rd_en_v[0]), .rd_data(d0), .rd_valid(rdv_w[0]), .fifo_full(full_w[0]),
        .overflow(ovf_w[0]), .frame_err(ferr_w[0]), .word_count(wc[0]));

    spi_word_rx #(.WORD_W(12), .CPOL(1'b1), .CPHA(1'b1)) dut1 (
        .clk(clk), .rst(rst), .spi_clk(sclk_v[1]), .spi_mosi(mosi), .spi_cs_n(csn_v[1]),
        .rd_en(rd_en_v[1]), .rd_data(d1), .rd_valid(rdv_w[1]), .fifo_full(full_w[1]),
        .overflow(ovf_w[1]), .frame_err(ferr_w[1]), .word_count(wc[1]));

    spi_word_rx #(.WORD_W(12), .CPOL(1'b0), .CPHA(1'b1)) dut2 (
        .clk(clk), .rst(rst), .spi_clk(sclk_v[2]), .spi_mosi(mosi), .spi_cs_n(csn_v[2]),
        .rd_en(rd_en_v[2]), .rd_data(d2), .rd_valid(rdv_w[2]), .fifo_full(full_w[2]),
        .overflow(ovf_w[2]), .frame_err(ferr_w[2]), .word_count(wc[2]));

`ifdef SPI_WORD_RX_TIMEOUT_EN
    spi_word_rx #(.WORD_W(8), .CPOL(1'b0), .CPHA(1'b0), .TIMEOUT_CYC(64)) dut3 (
        .clk(clk), .rst(rst), .spi_clk(sclk_v[3]), .spi_mosi(mosi), .spi_cs_n(csn_v[3]),
        .rd_en(rd_en_v[3]), .rd_data(d3), .rd_valid(rdv_w[3]), .fifo_full(full_w[3]),
        .overflow(ovf_w[3]), .frame_err(ferr_w[3]), .word_count(wc[3]));
`else
    assign d3       = 8'd0;
    assign rdv_w[3] = 1'b0;
    assign full_w[3] = 1'b0;
    assign ovf_w[3] = 1'b0;
    assign ferr_w[3] = 1'b0;
    assign wc[3]    = 16'd0;
`endif

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic cs_low(input int dev);
        @(negedge clk);
        csn_v[dev] = 1'b0;
        #H;
    endtask

    task automatic cs_high(input int dev);
        #H;
        csn_v[dev] = 1'b1;
        #(3 * H);
    endtask

    // Returns right after the final trailing clock edge of the word.
    task automatic send_word(input int dev, input logic [31:0] data, input int nbits,
                             input bit cpol, input bit cpha);
        for (int i = nbits - 1; i >= 0; i--) begin
            if (!cpha) begin
                mosi = data[i];
                #H;
                sclk_v[dev] = ~cpol;
                #H;
                sclk_v[dev] = cpol;
            end else begin
                sclk_v[dev] = ~cpol;
                mosi = data[i];
                #H;
                sclk_v[dev] = cpol;
                #H;
            end
        end
    endtask

    task automatic wait_valid(input int dev, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge clk);
            ok = rdv_w[dev];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (rdv_w[0] !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", rdv_w[0]); end
        checks++; if (wc[0] !== 16'd0) begin errors++; $display("FAIL reset_word_count got %0d want 0", wc[0]); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rdd[0] !== 32'd0) begin errors++; $display("FAIL reset_rd_data got %h want 0", rdd[0]); end
        checks++; if (full_w[0] !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full_w[0]); end
        checks++; if ({ovf_w[0], ferr_w[0]} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b want 00", {ovf_w[0], ferr_w[0]}); end
        checks++; if (rdv_w[1] !== 1'b0) begin errors++; $display("FAIL reset_rd_valid_m3 got %b want 0", rdv_w[1]); end
    endtask

    task automatic test_mode0();
        int fb, ob;
        do_reset();
        fb = ferr_cnt[0];
        ob = ovf_cnt[0];
        cs_low(0);
        send_word(0, 32'hA5, 8, 1'b0, 1'b0);
        checks++; if (rdv_w[0] !== 1'b0) begin errors++; $display("FAIL latency_early got %b want 0", rdv_w[0]); end
        #10;
        checks++; if (rdv_w[0] !== 1'b1) begin errors++; $display("FAIL latency_valid got %b want 1", rdv_w[0]); end
        checks++; if (rdd[0] !== 32'hA5) begin errors++; $display("FAIL mode0_data got %h want a5", rdd[0]); end
        cs_high(0);
        checks++; if (wc[0] !== 16'd1) begin errors++; $display("FAIL mode0_count got %0d want 1", wc[0]); end
        checks++; if (ferr_cnt[0] - fb !== 0 || ovf_cnt[0] - ob !== 0) begin errors++; $display("FAIL mode0_pulses ferr %0d ovf %0d want 0 0", ferr_cnt[0] - fb, ovf_cnt[0] - ob); end
        @(negedge clk);
        rd_en_v[0] = 1'b1;
        @(negedge clk);
        rd_en_v[0] = 1'b0;
        checks++; if (rdv_w[0] !== 1'b0 || rdd[0] !== 32'd0) begin errors++; $display("FAIL mode0_pop valid %b data %h want 0 0", rdv_w[0], rdd[0]); end
    endtask

    task automatic test_modes();
        bit ok;
        do_reset();
        cs_low(1);
        send_word(1, 32'hABC, 12, 1'b1, 1'b1);
        cs_high(1);
        wait_valid(1, ok);
        checks++; if (!ok || rdd[1] !== 32'hABC) begin errors++; $display("FAIL mode3_data valid %b got %h want abc", ok, rdd[1]); end
        checks++; if (wc[1] !== 16'd1) begin errors++; $display("FAIL mode3_count got %0d want 1", wc[1]); end
        cs_low(2);
        send_word(2, 32'h5A3, 12, 1'b0, 1'b1);
        cs_high(2);
        wait_valid(2, ok);
        checks++; if (!ok || rdd[2] !== 32'h5A3) begin errors++; $display("FAIL mode1_data valid %b got %h want 5a3", ok, rdd[2]); end
    endtask

    task automatic test_multi_word();
        int fb;
        do_reset();
        fb = ferr_cnt[0];
        cs_low(0);
        for (int w = 1; w <= 3; w++) send_word(0, 32'(w), 8, 1'b0, 1'b0);
        cs_high(0);
        checks++; if (wc[0] !== 16'd3) begin errors++; $display("FAIL multi_count got %0d want 3", wc[0]); end
        checks++; if (ferr_cnt[0] - fb !== 0) begin errors++; $display("FAIL multi_ferr got %0d want 0", ferr_cnt[0] - fb); end
        for (int w = 1; w <= 3; w++) begin
            @(negedge clk);
            checks++; if (rdv_w[0] !== 1'b1 || rdd[0] !== 32'(w)) begin errors++; $display("FAIL multi_pop%0d valid %b got %h want %h", w, rdv_w[0], rdd[0], w); end
            rd_en_v[0] = 1'b1;
            @(negedge clk);
            rd_en_v[0] = 1'b0;
        end
        checks++; if (rdv_w[0] !== 1'b0) begin errors++; $display("FAIL multi_empty got %b want 0", rdv_w[0]); end
    endtask

    task automatic test_frame_err();
        int fb;
        bit ok;
        do_reset();
        fb = ferr_cnt[0];
        cs_low(0);
        send_word(0, 32'h16, 5, 1'b0, 1'b0);
        cs_high(0);
        checks++; if (ferr_cnt[0] - fb !== 1) begin errors++; $display("FAIL ferr_pulse got %0d want 1", ferr_cnt[0] - fb); end
        checks++; if (rdv_w[0] !== 1'b0 || wc[0] !== 16'd0) begin errors++; $display("FAIL ferr_fifo valid %b count %0d want 0 0", rdv_w[0], wc[0]); end
        cs_low(0);
        send_word(0, 32'h3C, 8, 1'b0, 1'b0);
        cs_high(0);
        wait_valid(0, ok);
        checks++; if (!ok || rdd[0] !== 32'h3C || wc[0] !== 16'd1) begin errors++; $display("FAIL ferr_next data %h count %0d want 3c 1", rdd[0], wc[0]); end
        checks++; if (ferr_cnt[0] - fb !== 1) begin errors++; $display("FAIL ferr_next_pulse got %0d want 1", ferr_cnt[0] - fb); end
    endtask

    task automatic test_overflow();
        int ob;
        do_reset();
        ob = ovf_cnt[0];
        cs_low(0);
        for (int w = 0; w < 5; w++) send_word(0, 32'h10 + 32'(w), 8, 1'b0, 1'b0);
        cs_high(0);
        checks++; if (full_w[0] !== 1'b1) begin errors++; $display("FAIL ovf_full got %b want 1", full_w[0]); end
        checks++; if (ovf_cnt[0] - ob !== 1) begin errors++; $display("FAIL ovf_pulse got %0d want 1", ovf_cnt[0] - ob); end
        checks++; if (wc[0] !== 16'd4) begin errors++; $display("FAIL ovf_count got %0d want 4", wc[0]); end
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            checks++; if (rdv_w[0] !== 1'b1 || rdd[0] !== 32'h10 + 32'(w)) begin errors++; $display("FAIL ovf_pop%0d got %h want %h", w, rdd[0], 32'h10 + 32'(w)); end
            rd_en_v[0] = 1'b1;
            @(negedge clk);
            rd_en_v[0] = 1'b0;
        end
        checks++; if (rdv_w[0] !== 1'b0 || full_w[0] !== 1'b0) begin errors++; $display("FAIL ovf_drained valid %b full %b want 0 0", rdv_w[0], full_w[0]); end

        // Refill, then pop in exactly the cycle the fifth word is pushed.
        cs_low(0);
        for (int w = 0; w < 4; w++) send_word(0, 32'h20 + 32'(w), 8, 1'b0, 1'b0);
        send_word(0, 32'h24, 8, 1'b0, 1'b0);
        rd_en_v[0] = 1'b1;
        #10;
        rd_en_v[0] = 1'b0;
        cs_high(0);
        checks++; if (ovf_cnt[0] - ob !== 1) begin errors++; $display("FAIL pushpop_ovf got %0d want 1", ovf_cnt[0] - ob); end
        checks++; if (full_w[0] !== 1'b1 || wc[0] !== 16'd9) begin errors++; $display("FAIL pushpop_state full %b count %0d want 1 9", full_w[0], wc[0]); end
        for (int w = 1; w <= 4; w++) begin
            @(negedge clk);
            checks++; if (rdv_w[0] !== 1'b1 || rdd[0] !== 32'h20 + 32'(w)) begin errors++; $display("FAIL pushpop_pop%0d got %h want %h", w, rdd[0], 32'h20 + 32'(w)); end
            rd_en_v[0] = 1'b1;
            @(negedge clk);
            rd_en_v[0] = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        int fb;
        bit ok;
        do_reset();
        cs_low(0);
        send_word(0, 32'h11, 8, 1'b0, 1'b0);
        cs_high(0);
        cs_low(0);
        send_word(0, 32'hA, 4, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (rdv_w[0] !== 1'b0 || wc[0] !== 16'd0) begin errors++; $display("FAIL rstmid_clear valid %b count %0d want 0 0", rdv_w[0], wc[0]); end
        @(negedge clk);
        rst = 1'b0;
        fb = ferr_cnt[0];
        cs_high(0);
        checks++; if (ferr_cnt[0] - fb !== 0) begin errors++; $display("FAIL rstmid_ferr got %0d want 0", ferr_cnt[0] - fb); end
        cs_low(0);
        send_word(0, 32'h77, 8, 1'b0, 1'b0);
        cs_high(0);
        wait_valid(0, ok);
        checks++; if (!ok || rdd[0] !== 32'h77 || wc[0] !== 16'd1) begin errors++; $display("FAIL rstmid_next data %h count %0d want 77 1", rdd[0], wc[0]); end
    endtask

`ifdef SPI_WORD_RX_TIMEOUT_EN
    task automatic test_timeout();
        int fb;
        bit ok;
        do_reset();
        fb = ferr_cnt[3];
        cs_low(3);
        send_word(3, 32'h5, 3, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        checks++; if (ferr_cnt[3] - fb !== 0) begin errors++; $display("FAIL timeout_early got %0d want 0", ferr_cnt[3] - fb); end
        repeat (60) @(negedge clk);
        checks++; if (ferr_cnt[3] - fb !== 1) begin errors++; $display("FAIL timeout_ferr got %0d want 1", ferr_cnt[3] - fb); end
        send_word(3, 32'h55, 8, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        checks++; if (rdv_w[3] !== 1'b0 || wc[3] !== 16'd0) begin errors++; $display("FAIL timeout_locked valid %b count %0d want 0 0", rdv_w[3], wc[3]); end
        cs_high(3);
        cs_low(3);
        send_word(3, 32'h66, 8, 1'b0, 1'b0);
        cs_high(3);
        wait_valid(3, ok);
        checks++; if (!ok || rdd[3] !== 32'h66 || wc[3] !== 16'd1) begin errors++; $display("FAIL timeout_next data %h count %0d want 66 1", rdd[3], wc[3]); end
        checks++; if (ferr_cnt[3] - fb !== 1) begin errors++; $display("FAIL timeout_ferr_total got %0d want 1", ferr_cnt[3] - fb); end
    endtask
`endif

    initial begin
        test_reset();
        test_mode0();
        test_modes();
        test_multi_word();
        test_frame_err();
        test_overflow();
        test_reset_mid();
`ifdef SPI_WORD_RX_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
